wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 102 ++++++++++
 tb/tb_wb_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin N:1 Wishbone arbiter with cycle-long ownership.
// Define WB_ARBITER_TIMEOUT_EN to add a bus watchdog that errors stalled strobes.
module wb_arbiter #(
   parameter int MASTER_COUNT = 2,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int TAG_WIDTH = 3,
   parameter int TIMEOUT_CYCLES = 256,
   localparam int SEL_W = DATA_WIDTH / 8
) (
   input  logic                              sys_clk,
   input  logic                              sys_rst,
   input  logic [MASTER_COUNT-1:0]           master_cyc,
   input  logic [MASTER_COUNT-1:0]           master_stb,
   input  logic [MASTER_COUNT-1:0]           master_we,
   input  logic [MASTER_COUNT*TAG_WIDTH-1:0] master_tag,
   input  logic [MASTER_COUNT*SEL_W-1:0]     master_sel,
   input  logic [MASTER_COUNT*ADDR_WIDTH-1:0] master_adr,
   input  logic [MASTER_COUNT*DATA_WIDTH-1:0] master_mosi,
   output logic [MASTER_COUNT*DATA_WIDTH-1:0] master_miso,
   output logic [MASTER_COUNT-1:0]           master_ack,
   output logic [MASTER_COUNT-1:0]           master_err,
   output logic                              slave_cyc,
   output logic                              slave_stb,
   output logic                              slave_we,
   output logic [TAG_WIDTH-1:0]              slave_tag,
   output logic [SEL_W-1:0]                  slave_sel,
   output logic [ADDR_WIDTH-1:0]             slave_adr,
   output logic [DATA_WIDTH-1:0]             slave_mosi,
   input  logic [DATA_WIDTH-1:0]             slave_miso,
   input  logic                              slave_ack,
   input  logic                              slave_err
);
   localparam int OW = MASTER_COUNT > 1 ? $clog2(MASTER_COUNT) : 1;
   typedef enum logic {IDLE, OWNED} state_t;
   state_t state_q, state_d;
   logic [OW-1:0] owner_q, owner_d, last_q, last_d, cand;
   logic owned, to_q;
   assign owned = state_q == OWNED;
   // Scan from farthest to nearest so the nearest requester after last_q wins.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d = last_q;
      cand = '0;
      if (state_q == IDLE) begin
         for (int k = MASTER_COUNT; k >= 1; k--) begin
            cand = OW'((int'(last_q) + k) % MASTER_COUNT);
            if (master_cyc[cand]) owner_d = cand;
         end
         if (|master_cyc) state_d = OWNED;
      end else if (!master_cyc[owner_q]) begin
         state_d = IDLE;
         last_d = owner_q;
      end
   end
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q <= IDLE;
         owner_q <= '0;
         last_q <= OW'(MASTER_COUNT - 1);
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q <= last_d;
      end
   end
`ifdef WB_ARBITER_TIMEOUT_EN
   localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CW-1:0] cnt_q, cnt_d;
   logic to_d;
   always_comb begin
      to_d = 1'b0;
      cnt_d = '0;
      if (owned && slave_stb && !slave_ack && !slave_err) begin
         to_d = cnt_q == CW'(TIMEOUT_CYCLES - 1);
         cnt_d = to_d ? '0 : cnt_q + 1'b1;
      end
   end
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         cnt_q <= '0;
         to_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         to_q <= to_d;
      end
   end
`else
   assign to_q = 1'b0;
`endif
   assign slave_cyc = owned && master_cyc[owner_q] && !to_q;
   assign slave_stb = owned && master_stb[owner_q] && !to_q;
   assign slave_we = owned && master_we[owner_q];
   assign slave_tag = owned ? master_tag[owner_q*TAG_WIDTH +: TAG_WIDTH] : '0;
   assign slave_sel = owned ? master_sel[owner_q*SEL_W +: SEL_W] : '0;
   assign slave_adr = owned ? master_adr[owner_q*ADDR_WIDTH +: ADDR_WIDTH] : '0;
   assign slave_mosi = owned ? master_mosi[owner_q*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign master_ack = owned ? MASTER_COUNT'(slave_ack) << owner_q : '0;
   assign master_err = owned ? MASTER_COUNT'(slave_err | to_q) << owner_q : '0;
   assign master_miso = {MASTER_COUNT{slave_miso}};
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: vector table plus directed sequences for the 2-master arbiter.
module tb_wb_arbiter;
   localparam logic [31:0] A0 = 32'h0000_4000, A1 = 32'h0000_8000;
   localparam logic [31:0] D0 = 32'h1111_1111, D1 = 32'h2222_2222;
   logic sys_clk = 1'b0, sys_rst = 1'b1;
   logic [1:0] m_cyc = '0, m_stb = '0, m_we = 2'b10;
   logic [5:0] m_tag = {3'd2, 3'd1};
   logic [7:0] m_sel = {4'h3, 4'hF};
   logic [63:0] m_adr = {A1, A0}, m_mosi = {D1, D0}, m_miso;
   logic [1:0] m_ack, m_err;
   logic s_cyc, s_stb, s_we;
   logic [2:0] s_tag;
   logic [3:0] s_sel;
   logic [31:0] s_adr, s_mosi;
   logic [31:0] s_miso = 32'hDEAD_BEEF;
   logic s_ack = 1'b0, s_err = 1'b0;
   int total = 0, bad = 0;
   always #5 sys_clk = ~sys_clk;
   wb_arbiter #(.MASTER_COUNT(2), .DATA_WIDTH(32), .ADDR_WIDTH(32), .TAG_WIDTH(3), .TIMEOUT_CYCLES(16)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .master_cyc(m_cyc), .master_stb(m_stb), .master_we(m_we), .master_tag(m_tag),
      .master_sel(m_sel), .master_adr(m_adr), .master_mosi(m_mosi), .master_miso(m_miso),
      .master_ack(m_ack), .master_err(m_err),
      .slave_cyc(s_cyc), .slave_stb(s_stb), .slave_we(s_we), .slave_tag(s_tag),
      .slave_sel(s_sel), .slave_adr(s_adr), .slave_mosi(s_mosi), .slave_miso(s_miso),
      .slave_ack(s_ack), .slave_err(s_err)
   );
   typedef struct {
      logic [1:0] cyc, stb;
      logic ack, err;
      logic scyc, sstb, swe;
      logic [31:0] sadr;
      logic [1:0] mack, merr;
   } vec_t;
   vec_t vt[18];
   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask
   task automatic tick(input logic [1:0] c, input logic [1:0] s, input logic a, input logic e);
      @(posedge sys_clk);
      #1;
      sys_rst = 1'b0;
      m_cyc = c;
      m_stb = s;
      s_ack = a;
      s_err = e;
      @(negedge sys_clk);
   endtask
   task automatic do_reset();
      sys_rst = 1'b1;
      m_cyc = '0;
      m_stb = '0;
      s_ack = 1'b0;
      s_err = 1'b0;
      @(posedge sys_clk);
      tick(2'b00, 2'b00, 1'b0, 1'b0);
   endtask
   task automatic bus(input string nm, input logic scyc, input logic [31:0] adr, input logic [1:0] mack);
      chk({nm, " scyc"}, 64'(s_cyc), 64'(scyc));
      chk({nm, " adr"}, 64'(s_adr), 64'(adr));
      chk({nm, " ack"}, 64'(m_ack), 64'(mack));
   endtask
   initial begin
      int grants[$];
      int gaps[$];
      int beats[2];
      logic [1:0] drop;
      logic prev;
      int low_run, own, n;
      logic [31:0] emosi;
      logic exp_to;
      vt = '{
         '{2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00},
         '{2'b01, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, A0,    2'b00, 2'b00},
         '{2'b01, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, A0,    2'b01, 2'b00},
         '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, A0,    2'b00, 2'b00},
         '{2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00},
         '{2'b11, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, A1,    2'b10, 2'b00},
         '{2'b11, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, A1,    2'b00, 2'b10},
         '{2'b11, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, A1,    2'b00, 2'b00},
         '{2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, A1,    2'b00, 2'b00},
         '{2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00},
         '{2'b01, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, A0,    2'b01, 2'b00},
         '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, A0,    2'b00, 2'b00},
         '{2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00},
         '{2'b11, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, A0,    2'b00, 2'b00},
         '{2'b01, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, A0,    2'b00, 2'b00},
         '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, A0,    2'b00, 2'b00},
         '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00},
         '{2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00}
      };
      do_reset();
      chk("rst scyc", 64'(s_cyc), 64'd0);
      chk("rst stb", 64'(s_stb), 64'd0);
      chk("rst adr", 64'(s_adr), 64'd0);
      chk("rst ackerr", 64'({m_ack, m_err}), 64'd0);
      for (int i = 0; i < 18; i++) begin
         tick(vt[i].cyc, vt[i].stb, vt[i].ack, vt[i].err);
         emosi = vt[i].sadr == A0 ? D0 : vt[i].sadr == A1 ? D1 : 32'h0;
         chk($sformatf("v%0d scyc", i), 64'(s_cyc), 64'(vt[i].scyc));
         chk($sformatf("v%0d sstb", i), 64'(s_stb), 64'(vt[i].sstb));
         chk($sformatf("v%0d swe", i), 64'(s_we), 64'(vt[i].swe));
         chk($sformatf("v%0d sadr", i), 64'(s_adr), 64'(vt[i].sadr));
         chk($sformatf("v%0d smosi", i), 64'(s_mosi), 64'(emosi));
         chk($sformatf("v%0d mack", i), 64'(m_ack), 64'(vt[i].mack));
         chk($sformatf("v%0d merr", i), 64'(m_err), 64'(vt[i].merr));
         chk($sformatf("v%0d miso", i), m_miso, {2{32'hDEAD_BEEF}});
      end
      // Two masters each take 3 acked beats, drop cyc for one cycle, then re-request.
      do_reset();
      drop = '0;
      beats = '{0, 0};
      prev = 1'b0;
      low_run = 0;
      for (int c = 0; c < 30; c++) begin
         tick(~drop, ~drop, 1'b1, 1'b0);
         for (int i = 0; i < 2; i++) if (!m_cyc[i]) drop[i] = 1'b0;
         if (s_cyc) begin
            own = s_adr == A1 ? 1 : 0;
            if (!prev) begin
               if (grants.size() > 0) gaps.push_back(low_run);
               grants.push_back(own);
            end
            low_run = 0;
            if (m_ack[own]) beats[own]++;
            if (beats[own] == 3) begin
               beats[own] = 0;
               drop[own] = 1'b1;
            end
         end else low_run++;
         prev = s_cyc;
      end
      chk("rr grants>=4", 64'(grants.size() >= 4), 64'd1);
      n = grants.size() < 4 ? grants.size() : 4;
      for (int k = 0; k < n; k++) chk($sformatf("rr grant%0d", k), 64'(grants[k]), 64'(k % 2));
      n = gaps.size() < 3 ? gaps.size() : 3;
      // Gap = the release cycle plus exactly one idle cycle.
      for (int k = 0; k < n; k++) chk($sformatf("rr gap%0d", k), 64'(gaps[k]), 64'd2);
      // Master1 owns for 4 beats; master0 requests at beat 2 and must wait.
      do_reset();
      tick(2'b10, 2'b10, 1'b0, 1'b0); bus("hold c0", 1'b0, 32'h0, 2'b00);
      tick(2'b10, 2'b10, 1'b1, 1'b0); bus("hold b1", 1'b1, A1, 2'b10);
      tick(2'b11, 2'b11, 1'b1, 1'b0); bus("hold b2", 1'b1, A1, 2'b10);
      tick(2'b11, 2'b11, 1'b1, 1'b0); bus("hold b3", 1'b1, A1, 2'b10);
      tick(2'b11, 2'b11, 1'b1, 1'b0); bus("hold b4", 1'b1, A1, 2'b10);
      tick(2'b01, 2'b01, 1'b0, 1'b0); bus("hold rel", 1'b0, A1, 2'b00);
      tick(2'b01, 2'b01, 1'b0, 1'b0); bus("hold idle", 1'b0, 32'h0, 2'b00);
      tick(2'b01, 2'b01, 1'b1, 1'b0); bus("hold m0", 1'b1, A0, 2'b01);
      tick(2'b00, 2'b00, 1'b0, 1'b0);
      tick(2'b00, 2'b00, 1'b0, 1'b0);
      // Reset while master0 owns with a pending strobe; last owner was 0 beforehand.
      tick(2'b01, 2'b01, 1'b0, 1'b0);
      tick(2'b01, 2'b01, 1'b0, 1'b0); bus("rst own", 1'b1, A0, 2'b00);
      sys_rst = 1'b1;
      tick(2'b11, 2'b11, 1'b0, 1'b0);
      bus("rst abort", 1'b0, 32'h0, 2'b00);
      chk("rst abort stb", 64'(s_stb), 64'd0);
      chk("rst abort err", 64'(m_err), 64'd0);
      tick(2'b11, 2'b11, 1'b0, 1'b0); bus("rst first", 1'b1, A0, 2'b00);
      tick(2'b00, 2'b00, 1'b0, 1'b0);
      tick(2'b00, 2'b00, 1'b0, 1'b0);
      // Slave never acks: watchdog fires 16 cycles after stb rises, if built in.
      tick(2'b01, 2'b01, 1'b0, 1'b0);
      for (int k = 0; k <= 20; k++) begin
         tick(2'b01, 2'b01, 1'b0, 1'b0);
`ifdef WB_ARBITER_TIMEOUT_EN
         exp_to = k == 16;
`else
         exp_to = 1'b0;
`endif
         chk($sformatf("wd%0d scyc", k), 64'(s_cyc), 64'(!exp_to));
         chk($sformatf("wd%0d sstb", k), 64'(s_stb), 64'(!exp_to));
         chk($sformatf("wd%0d merr", k), 64'(m_err), exp_to ? 64'd1 : 64'd0);
      end
      tick(2'b00, 2'b00, 1'b0, 1'b0);
      tick(2'b00, 2'b00, 1'b0, 1'b0);
      bus("end idle", 1'b0, 32'h0, 2'b00);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
